if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 SHALL have port imem_rsp_data  input  32  returned instruction.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken; restart fetch.
REQ-010 SHALL have port redirect_pc  input  32  restart target.
REQ-011 SHALL have port stall  input  1  decode cannot accept; hold IF/ID outputs.
REQ-012 SHALL have port if_valid  output  1  IF/ID register holds a live instruction.
REQ-013 SHALL have port if_pc  output  32  PC of if_inst.
REQ-014 SHALL have port if_inst  output  32  instruction word presented to decode.

Function
REQ-015 SHALL keep at most one request outstanding (accepted, response not yet received).
REQ-016 SHALL use FSM S_REQ (drive imem_req_valid), S_WAIT (outstanding, live), S_DROP (outstanding, stale).
REQ-017 SHALL in S_REQ assert imem_req_valid only when the fetch buffer is empty; hold imem_req_addr stable until imem_req_ready.
REQ-018 SHALL on request handshake move S_REQ->S_WAIT and advance fetch PC by 4 (modulo 2^32, wrap silently).
REQ-019 SHALL accept responses with any latency >=1 cycle after handshake; response in S_WAIT writes {pc,inst} into the one-entry fetch buffer and returns to S_REQ.
REQ-020 SHALL load the IF/ID register from the buffer when buffer valid and (!if_valid or !stall); buffer empties same cycle; otherwise IF/ID holds all outputs unchanged.
REQ-021 SHALL clear if_valid when IF/ID is consumed (!stall) and the buffer is empty.
REQ-022 SHALL on redirect_valid: clear if_valid and buffer, set fetch PC to {redirect_pc[31:2],2'b00}, go S_REQ if nothing outstanding, else S_DROP.
REQ-023 SHALL treat a request handshaking in the same cycle as redirect_valid as stale (go S_DROP).
REQ-024 SHALL in S_DROP discard the response, then go S_REQ; a further redirect in S_DROP only updates fetch PC.
REQ-025 SHALL give redirect priority over stall and over a same-cycle response.
REQ-026 SHALL achieve back-to-back throughput of one instruction per two cycles with 1-cycle memory latency, no stall.

Reset
REQ-027 SHALL on rst: fetch PC=RESET_PC, state S_REQ, buffer empty, if_valid=0, if_pc=0, if_inst=32'h0000_0013 (NOP), imem_req_valid=0 during reset.
REQ-028 SHALL discard any response arriving in the first cycle after reset deassertion if a request was outstanding at reset assertion (enter S_DROP not required: memory is reset concurrently).

Structure
REQ-029 SHALL place the state enum, fetch-packet struct {pc, inst}, NOP constant and RESET_PC default in shared package core_pkg.
REQ-030 SHALL implement the one-entry fetch buffer as sub-module fetch_buf (valid/ready in, valid/ready out, flush).

Verification
REQ-031 SHALL cover reset release, ready=1, 1-cycle latency, words 0x00500093,0x00100113 -> if_pc 0x80000000 then 0x80000004 with matching if_inst.
REQ-032 SHALL cover stall held 5 cycles with if_valid=1 -> if_pc/if_inst unchanged, imem_req_valid low once buffer full, no instruction lost or duplicated.
REQ-033 SHALL cover redirect to 0x80000102 while request outstanding -> stale response dropped, next request addr 0x80000100, if_valid=0 until its response.
REQ-034 SHALL cover imem_req_ready low 3 cycles -> imem_req_addr constant, no PC advance.
REQ-035 SHALL cover fetch PC 0xFFFFFFFC -> next request address 0x00000000.
REQ-036 SHALL cover rst asserted mid-S_WAIT -> outputs immediately at reset values, first post-reset request addr RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the fetch FSM encoding, the {pc, inst} packet and the reset/NOP constants.
package core_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/fetch_buf.sv
// One-entry fetch buffer between the memory response and the IF/ID register.
// Zero-cycle ready path: accepts when empty or being drained this cycle; flush empties it.
module fetch_buf
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_vld,
  output logic       in_rdy,
  input  fetch_pkt_t in_dat,
  output logic       out_vld,
  input  logic       out_rdy,
  output fetch_pkt_t out_dat
);

  logic       full;
  fetch_pkt_t data;

  assign in_rdy  = !full || out_rdy;
  assign out_vld = full;
  assign out_dat = data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (in_vld && in_rdy) begin
      full <= 1'b1;
      data <= in_dat;
    end else if (out_rdy) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, one-entry buffer, IF/ID register.
// Two cycles per instruction at 1-cycle memory latency; stall holds IF/ID and stops new requests once the buffer fills.
module if_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic         req_fire;
  logic         buf_in_vld, buf_in_rdy, buf_out_vld, buf_out_rdy;
  fetch_pkt_t   buf_in_dat, buf_out_dat;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Request may go out while the buffer drains, which is what gives 2-cycle throughput.
  assign imem_req_valid = !rst && (state == S_REQ) && buf_in_rdy;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign buf_in_vld  = imem_rsp_valid && (state == S_WAIT) && !redirect_valid;
  assign buf_in_dat  = '{pc: req_pc, inst: imem_rsp_data};
  assign buf_out_rdy = !redirect_valid && (!if_valid || !stall);

  fetch_buf u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .in_vld  (buf_in_vld),
    .in_rdy  (buf_in_rdy),
    .in_dat  (buf_in_dat),
    .out_vld (buf_out_vld),
    .out_rdy (buf_out_rdy),
    .out_dat (buf_out_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (req_fire) state_nxt = redirect_valid ? S_DROP : S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_nxt = S_REQ;
               else if (redirect_valid) state_nxt = S_DROP;
      S_DROP:  if (imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
      if (req_fire) req_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP_INST;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (buf_out_vld && buf_out_rdy) begin
      if_valid <= 1'b1;
      if_pc    <= buf_out_dat.pc;
      if_inst  <= buf_out_dat.inst;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small latency-programmable instruction memory model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int tests_run = 0;
  int tests_failed = 0;

  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          lat = 0;
  int          mem_lat = 1;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_word = 32'h0050_0093;
      32'h8000_0004: mem_word = 32'h0010_0113;
      default:       mem_word = a ^ 32'h1234_5678;
    endcase
  endfunction

  // One clock: sample the request handshake, then drive this cycle's memory response at negedge.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    @(posedge clk);
    if (hs) begin
      pend = 1'b1; pend_addr = a; lat = mem_lat;
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (pend) begin
      lat--;
      if (lat == 0) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(pend_addr); pend = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; pend = 1'b0; mem_lat = 1;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    tests_run++; if (if_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_if_pc: got %h want 00000000", if_pc); end
    tests_run++; if (if_inst !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_if_inst: got %h want 00000013", if_inst); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rst = 1'b0;
    #1;
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL b2b_first_req: got vld %b addr %h want 1 80000000", imem_req_valid, imem_req_addr); end
    tick(); tick(); tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000) begin tests_failed++; $display("FAIL b2b_pc0: got vld %b pc %h want 1 80000000", if_valid, if_pc); end
    tests_run++; if (if_inst !== 32'h0050_0093) begin tests_failed++; $display("FAIL b2b_inst0: got %h want 00500093", if_inst); end
    tick();
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap: got vld %b want 0", if_valid); end
    tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0004) begin tests_failed++; $display("FAIL b2b_pc1: got vld %b pc %h want 1 80000004", if_valid, if_pc); end
    tests_run++; if (if_inst !== 32'h0010_0113) begin tests_failed++; $display("FAIL b2b_inst1: got %h want 00100113", if_inst); end
  endtask

  task automatic test_stall();
    do_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_req_low[%0d]: got %b want 0", i, imem_req_valid); end
      tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000 || if_inst !== 32'h0050_0093) begin tests_failed++; $display("FAIL stall_hold[%0d]: got %b %h %h want 1 80000000 00500093", i, if_valid, if_pc, if_inst); end
      tick();
    end
    stall = 1'b0;
    #1;
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin tests_failed++; $display("FAIL stall_resume_req: got %b %h want 1 80000008", imem_req_valid, imem_req_addr); end
    tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0004 || if_inst !== 32'h0010_0113) begin tests_failed++; $display("FAIL stall_next: got %b %h %h want 1 80000004 00100113", if_valid, if_pc, if_inst); end
    tick(); tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0008 || if_inst !== 32'h9234_5670) begin tests_failed++; $display("FAIL stall_after: got %b %h %h want 1 80000008 92345670", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_lat = 3;
    rst = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    #1;
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_req_low0: got %b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    tests_run++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_drop_wait: got req %b ifv %b want 0 0", imem_req_valid, if_valid); end
    tick();
    #1;
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_drop_rsp: got req %b want 0", imem_req_valid); end
    tick();
    #1;
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin tests_failed++; $display("FAIL redir_new_req: got %b %h want 1 80000100", imem_req_valid, imem_req_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_ifv_low[%0d]: got %b want 0", i, if_valid); end
    end
    tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0100 || if_inst !== 32'h9234_5778) begin tests_failed++; $display("FAIL redir_target: got %b %h %h want 1 80000100 92345778", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    rst = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL samecyc_drop: got req %b want 0", imem_req_valid); end
    tick();
    #1;
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin tests_failed++; $display("FAIL samecyc_req: got %b %h want 1 80000200", imem_req_valid, imem_req_addr); end
    tick(); tick(); tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0200 || if_inst !== 32'h9234_5478) begin tests_failed++; $display("FAIL samecyc_target: got %b %h %h want 1 80000200 92345478", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_ready_low();
    do_reset();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL rdy_low_hold[%0d]: got %b %h want 1 80000000", i, imem_req_valid, imem_req_addr); end
      tick();
    end
    imem_req_ready = 1'b1;
    #1;
    tests_run++; if (imem_req_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL rdy_release_addr: got %h want 80000000", imem_req_addr); end
    tick(); tick();
    #1;
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin tests_failed++; $display("FAIL rdy_next_addr: got %b %h want 1 80000004", imem_req_valid, imem_req_addr); end
    tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000) begin tests_failed++; $display("FAIL rdy_if_pc: got %b %h want 1 80000000", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_req0: got %b %h want 1 fffffffc", imem_req_valid, imem_req_addr); end
    tick(); tick();
    #1;
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_req1: got %b %h want 1 00000000", imem_req_valid, imem_req_addr); end
    tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_inst !== 32'hEDCB_A984) begin tests_failed++; $display("FAIL wrap_if: got %b %h %h want 1 fffffffc edcba984", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    rst = 1'b0;
    tick(); tick();
    mem_lat = 3;
    tick();
    rst = 1'b1;
    #1;
    tests_run++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0000_0013) begin tests_failed++; $display("FAIL midrst_if: got %b %h %h want 0 00000000 00000013", if_valid, if_pc, if_inst); end
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_req: got %b want 0", imem_req_valid); end
    tick(); tick();
    rst = 1'b0; mem_lat = 1;
    #1;
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL midrst_first_req: got %b %h want 1 80000000", imem_req_valid, imem_req_addr); end
    tick();
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_stale: got ifv %b want 0", if_valid); end
    tick(); tick();
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000 || if_inst !== 32'h0050_0093) begin tests_failed++; $display("FAIL midrst_if_after: got %b %h %h want 1 80000000 00500093", if_valid, if_pc, if_inst); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_ready_low();
    test_wrap();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
